secuenciador_ejecucion: RTL and testbench
=========================================

# secuenciador_ejecucion

Execution sequencer for the MIPS pipeline. It gates the program counter in continuous or single-step mode and detects the HALT opcode on the fetched instruction. After each step, or at halt, it walks the database fields and streams every 32-bit word MSB-first to the UART transmitter. It sits between the debug unit's command decoder, the IF stage, the database and the tx module, and takes over PC enable, database select and the tx handshake.

## Interface
Parameters:
- ADDR_LENGTH, 11, width of PC and cycle counter
- LONGITUD_INSTRUCCION, 32, instruction and database word width
- HALT_OPCODE, 0, 6-bit opcode value that stops execution
- CANT_BITS_CONTROL, 3, width of the database select
- CANT_DATOS_DB, 4, number of database fields dumped per report (1..2^CANT_BITS_CONTROL)
- OUTPUT_WORD_LENGTH, 8, UART byte width

Ports:
- i_clock  in  1  single system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse; begins execution (IDLE) or acknowledges end (DONE)
- i_modo  in  1  sampled at i_start: 0 = continuous, 1 = step
- i_step  in  1  one-cycle pulse; advances one cycle in step mode
- i_instruction_fetch  in  LONGITUD_INSTRUCCION  current IF instruction
- i_dato_database  in  LONGITUD_INSTRUCCION  database word selected by o_control_database (1-cycle latency)
- i_tx_done  in  1  one-cycle pulse from tx: byte finished
- o_enable_PC  out  1  PC/pipeline advance enable
- o_control_database  out  CANT_BITS_CONTROL  database field select
- o_tx_start  out  1  one-cycle pulse requesting a byte send
- o_data_tx  out  OUTPUT_WORD_LENGTH  byte to send
- o_busy  out  1  high in any state except IDLE and DONE
- o_halted  out  1  HALT seen; held until return to IDLE
- o_estado  out  3  current state encoding, for LEDs

## Operation
- States:
  - IDLE=0
  - RUN=1
  - STEP_WAIT=2
  - EXEC_STEP=3
  - DUMP_SEL=4
  - DUMP_SEND=5
  - DUMP_WAIT=6
  - DONE=7
- halt = (i_instruction_fetch[31:26] == HALT_OPCODE).
- IDLE:
  - i_start latches i_modo.
  - i_modo=0 goes to RUN; i_modo=1 goes to STEP_WAIT.
- RUN:
  - o_enable_PC = !halt (combinational from state and input).
  - On halt: set o_halted, go to DUMP_SEL with field index 0.
- STEP_WAIT:
  - i_step goes to EXEC_STEP.
  - i_start is ignored.
  - If halted, report once more and go to DONE.
- EXEC_STEP:
  - One cycle. o_enable_PC = !halt.
  - If halt, set o_halted.
  - Always go to DUMP_SEL.
- DUMP_SEL:
  - o_control_database = field index.
  - One cycle for database latency.
  - Latch i_dato_database into a shift register on exit; byte count = 0.
- DUMP_SEND:
  - o_tx_start = 1 for exactly one cycle.
  - o_data_tx = shift register [31:24].
  - Go to DUMP_WAIT.
- DUMP_WAIT:
  - Wait for i_tx_done, then shift left by 8 and increment byte count.
  - After 4 bytes, increment field index.
  - If field index < CANT_DATOS_DB, go to DUMP_SEL; else go to the end of report.
- End of report:
  - Continuous mode goes to DONE.
  - Step mode goes to DONE if o_halted, else to STEP_WAIT.
- DONE:
  - i_start clears o_halted and returns to IDLE.

## Timing
- Reset values of all outputs and registers are 0: o_enable_PC, o_control_database, o_tx_start, o_data_tx, o_busy, o_halted, o_estado=IDLE. Field index, byte count and shift register also clear.
- Reset mid-dump aborts immediately; no partial-byte recovery.
- o_enable_PC is never high outside RUN and EXEC_STEP.
- In RUN it drops in the same cycle HALT is presented, so the HALT instruction is not advanced past.
- Report latency: per field, 1 select cycle, then 4 × (1 start cycle + tx time).
- o_data_tx is stable from the o_tx_start cycle until i_tx_done.
- i_tx_done outside DUMP_WAIT is ignored.
- i_step outside STEP_WAIT is ignored, and is not queued.
- i_start and i_step in the same STEP_WAIT cycle: i_step wins.

## Configuration
- SECUENCIADOR_WATCHDOG_EN defined:
  - An ADDR_LENGTH-bit counter runs in RUN.
  - When it reaches 2^ADDR_LENGTH−1 cycles without halt, RUN is treated as halted (o_halted=1) and the report is sent.
  - The counter clears on entry to RUN.
- Undefined: no counter; RUN continues indefinitely until HALT.

## Test plan
- Continuous mode:
  - Stimulus: reset, i_start with i_modo=0; opcode non-zero for 5 cycles, then opcode 0.
  - Response: o_enable_PC high exactly 5 cycles; o_halted=1; 16 o_tx_start pulses; o_control_database steps 0,1,2,3; ends in DONE.
- Byte order:
  - Stimulus: database word 0xDEADBEEF for field 0.
  - Response: bytes sent 0xDE, 0xAD, 0xBE, 0xEF, each only after the previous i_tx_done.
- Step mode:
  - Stimulus: i_modo=1, three i_step pulses, non-halt instructions.
  - Response: o_enable_PC pulses exactly once per step; full 16-byte report after each step; returns to STEP_WAIT.
- Step reaching HALT:
  - Response: o_halted set, report sent, DONE.
  - Then i_start returns to IDLE with o_halted=0.
- Reset mid-dump:
  - Stimulus: assert i_reset after the second byte.
  - Response: all outputs 0 asynchronously; state IDLE; late i_tx_done ignored.
- Watchdog (SECUENCIADOR_WATCHDOG_EN):
  - Stimulus: no HALT for 2047 cycles.
  - Response: forced halt with o_halted=1 and report sent.

Source files
------------

// File: rtl/secuenciador_ejecucion.sv
// Execution sequencer: gates the PC in continuous or single-step mode, detects HALT and streams
// the database fields MSB-first to the UART. Optional watchdog: SECUENCIADOR_WATCHDOG_EN.
module secuenciador_ejecucion #(
  parameter int ADDR_LENGTH          = 11,
  parameter int LONGITUD_INSTRUCCION = 32,
  parameter int HALT_OPCODE          = 0,
  parameter int CANT_BITS_CONTROL    = 3,
  parameter int CANT_DATOS_DB        = 4,
  parameter int OUTPUT_WORD_LENGTH   = 8
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic                            i_modo,
  input  logic                            i_step,
  input  logic [LONGITUD_INSTRUCCION-1:0] i_instruction_fetch,
  input  logic [LONGITUD_INSTRUCCION-1:0] i_dato_database,
  input  logic                            i_tx_done,
  output logic                            o_enable_PC,
  output logic [CANT_BITS_CONTROL-1:0]    o_control_database,
  output logic                            o_tx_start,
  output logic [OUTPUT_WORD_LENGTH-1:0]   o_data_tx,
  output logic                            o_busy,
  output logic                            o_halted,
  output logic [2:0]                      o_estado
);

  localparam int CampoW          = CANT_BITS_CONTROL + 1;
  localparam int BytesPorPalabra = LONGITUD_INSTRUCCION / OUTPUT_WORD_LENGTH;
  localparam int BcW             = (BytesPorPalabra > 1) ? $clog2(BytesPorPalabra) : 1;

  localparam logic [CampoW-1:0] NumCampos  = CampoW'(CANT_DATOS_DB);
  localparam logic [BcW-1:0]    UltimoByte = BcW'(BytesPorPalabra - 1);
  localparam logic [5:0]        HaltOp     = 6'(HALT_OPCODE);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRun      = 3'd1,
    StStepWait = 3'd2,
    StExecStep = 3'd3,
    StDumpSel  = 3'd4,
    StDumpSend = 3'd5,
    StDumpWait = 3'd6,
    StDone     = 3'd7
  } estado_e;

  estado_e                         estado_q, estado_d, fin_reporte;
  logic                            modo_q, modo_d;
  logic                            halted_q, halted_d;
  logic [CampoW-1:0]               campo_q, campo_d;
  logic [BcW-1:0]                  bytes_q, bytes_d;
  logic [LONGITUD_INSTRUCCION-1:0] shift_q, shift_d;
  logic                            halt;
  logic                            wd_expira;
  logic                            unused_bits;

  assign halt        = (i_instruction_fetch[LONGITUD_INSTRUCCION-1 -: 6] == HaltOp);
  assign unused_bits = ^i_instruction_fetch[LONGITUD_INSTRUCCION-7:0];

`ifdef SECUENCIADOR_WATCHDOG_EN
  logic [ADDR_LENGTH-1:0] wd_q;

  // Held at zero outside RUN, so it is always clear on entry.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                 wd_q <= '0;
    else if (estado_q != StRun)  wd_q <= '0;
    else                         wd_q <= wd_q + 1'b1;
  end

  assign wd_expira = (estado_q == StRun) && (wd_q == '1);
`else
  assign wd_expira = 1'b0;
`endif

  always_comb begin
    estado_d    = estado_q;
    modo_d      = modo_q;
    halted_d    = halted_q;
    campo_d     = campo_q;
    bytes_d     = bytes_q;
    shift_d     = shift_q;
    o_enable_PC = 1'b0;
    o_tx_start  = 1'b0;
    fin_reporte = (modo_q && !halted_q) ? StStepWait : StDone;

    unique case (estado_q)
      StIdle: begin
        if (i_start) begin
          modo_d   = i_modo;
          estado_d = i_modo ? StStepWait : StRun;
        end
      end
      StRun: begin
        // Combinational so the HALT instruction itself is never advanced past.
        o_enable_PC = !halt && !wd_expira;
        if (halt || wd_expira) begin
          halted_d = 1'b1;
          campo_d  = '0;
          estado_d = StDumpSel;
        end
      end
      StStepWait: begin
        if (i_step) begin
          estado_d = StExecStep;
        end else if (halted_q) begin
          campo_d  = '0;
          estado_d = StDumpSel;
        end
      end
      StExecStep: begin
        o_enable_PC = !halt;
        if (halt) halted_d = 1'b1;
        campo_d  = '0;
        estado_d = StDumpSel;
      end
      StDumpSel: begin
        shift_d  = i_dato_database;
        bytes_d  = '0;
        estado_d = StDumpSend;
      end
      StDumpSend: begin
        o_tx_start = 1'b1;
        estado_d   = StDumpWait;
      end
      StDumpWait: begin
        if (i_tx_done) begin
          shift_d = shift_q << OUTPUT_WORD_LENGTH;
          bytes_d = bytes_q + 1'b1;
          if (bytes_q != UltimoByte) begin
            estado_d = StDumpSend;
          end else if ((campo_q + 1'b1) < NumCampos) begin
            campo_d  = campo_q + 1'b1;
            estado_d = StDumpSel;
          end else begin
            campo_d  = '0;
            estado_d = fin_reporte;
          end
        end
      end
      StDone: begin
        if (i_start) begin
          halted_d = 1'b0;
          estado_d = StIdle;
        end
      end
      default: estado_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      estado_q <= StIdle;
      modo_q   <= 1'b0;
      halted_q <= 1'b0;
      campo_q  <= '0;
      bytes_q  <= '0;
      shift_q  <= '0;
    end else begin
      estado_q <= estado_d;
      modo_q   <= modo_d;
      halted_q <= halted_d;
      campo_q  <= campo_d;
      bytes_q  <= bytes_d;
      shift_q  <= shift_d;
    end
  end

  assign o_control_database = campo_q[CANT_BITS_CONTROL-1:0];
  assign o_data_tx          = shift_q[LONGITUD_INSTRUCCION-1 -: OUTPUT_WORD_LENGTH];
  assign o_busy             = (estado_q != StIdle) && (estado_q != StDone);
  assign o_halted           = halted_q;
  assign o_estado           = estado_q;

endmodule

// File: tb/tb_secuenciador_ejecucion.sv
// Scoreboard bench for secuenciador_ejecucion: a program/database model feeds the DUT and the
// expected report bytes and field selects are queued, then checked by an independent monitor.
module tb_secuenciador_ejecucion;

  localparam int ND = 4;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_modo  = 1'b0;
  logic        i_step  = 1'b0;
  logic        i_tx_done = 1'b0;
  logic [31:0] i_instruction_fetch;
  logic [31:0] i_dato_database;
  logic        o_enable_PC, o_tx_start, o_busy, o_halted;
  logic [2:0]  o_control_database, o_estado;
  logic [7:0]  o_data_tx;

  secuenciador_ejecucion dut (
    .i_clock             (i_clock),
    .i_reset             (i_reset),
    .i_start             (i_start),
    .i_modo              (i_modo),
    .i_step              (i_step),
    .i_instruction_fetch (i_instruction_fetch),
    .i_dato_database     (i_dato_database),
    .i_tx_done           (i_tx_done),
    .o_enable_PC         (o_enable_PC),
    .o_control_database  (o_control_database),
    .o_tx_start          (o_tx_start),
    .o_data_tx           (o_data_tx),
    .o_busy              (o_busy),
    .o_halted            (o_halted),
    .o_estado            (o_estado)
  );

  always #5 i_clock = ~i_clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_bytes[$];
  int          exp_campos[$];
  logic [31:0] prog[64];
  logic [31:0] db[8];
  logic [10:0] pc;
  int          en_cnt;
  int          tx_cnt   = 0;
  int          done_cnt = 0;
  int          tx_delay = -1;
  logic        manual_done = 1'b0;
  logic [7:0]  byte_en_vuelo = 8'd0;

  // Program memory indexed by a PC that advances only when the DUT enables it.
  assign i_instruction_fetch = prog[pc[5:0]];
  assign i_dato_database     = db[o_control_database];

  task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nombre, got, exp);
    end
  endtask

  always @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      pc     <= '0;
      en_cnt <= 0;
    end else if (o_enable_PC) begin
      pc     <= pc + 1'b1;
      en_cnt <= en_cnt + 1;
    end
  end

  // UART model: answers each start with a done pulse after a random delay.
  always @(negedge i_clock) begin
    i_tx_done = manual_done;
    if (o_tx_start && !i_reset) chk("start_sin_done_previo", 32'(tx_delay < 0), 32'd1);
    if (i_reset) begin
      tx_delay = -1;
    end else if (tx_delay == 0) begin
      chk("byte_estable", 32'(o_data_tx), 32'(byte_en_vuelo));
      i_tx_done = 1'b1;
      tx_delay  = -1;
      done_cnt++;
    end else if (tx_delay > 0) begin
      tx_delay--;
    end else if (o_tx_start) begin
      byte_en_vuelo = o_data_tx;
      tx_delay      = $urandom_range(0, 3);
    end
  end

  // Scoreboard monitor.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (o_tx_start) begin
        tx_cnt++;
        if (exp_bytes.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL byte_inesperado: got 0x%0h expected none", o_data_tx);
        end else begin
          chk("byte", 32'(o_data_tx), 32'(exp_bytes.pop_front()));
        end
      end
      if (o_estado == 3'd4) begin
        if (exp_campos.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL campo_inesperado: got %0d expected none", o_control_database);
        end else begin
          chk("campo", 32'(o_control_database), 32'(exp_campos.pop_front()));
        end
      end
      if (o_enable_PC) chk("enable_fuera_de_run", 32'(o_estado == 3'd1 || o_estado == 3'd3), 32'd1);
    end
  end

  task automatic cargar_prog(input int idx_halt);
    for (int i = 0; i < 64; i++) prog[i] = {6'($urandom_range(1, 63)), 26'($urandom)};
    if (idx_halt < 64) prog[idx_halt][31:26] = 6'd0;
  endtask

  task automatic cargar_db();
    for (int i = 0; i < 8; i++) db[i] = $urandom;
  endtask

  task automatic esperar_reporte();
    for (int f = 0; f < ND; f++) begin
      exp_campos.push_back(f);
      for (int b = 0; b < 4; b++) exp_bytes.push_back(8'(db[f] >> (24 - 8 * b)));
    end
  endtask

  task automatic esperar(input logic [2:0] st, input int presupuesto, input string nombre);
    int i = 0;
    do begin
      @(negedge i_clock);
      i++;
    end while (o_estado != st && i < presupuesto);
    if (o_estado != st) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: got state %0d expected %0d", nombre, o_estado, st);
    end
  endtask

  task automatic pulso(input logic start, input logic step, input logic modo);
    @(negedge i_clock);
    i_start = start;
    i_step  = step;
    i_modo  = modo;
    @(negedge i_clock);
    i_start = 1'b0;
    i_step  = 1'b0;
  endtask

  task automatic chk_ceros(input string p);
    chk({p, "_enable"}, 32'(o_enable_PC), 32'd0);
    chk({p, "_control"}, 32'(o_control_database), 32'd0);
    chk({p, "_tx_start"}, 32'(o_tx_start), 32'd0);
    chk({p, "_data_tx"}, 32'(o_data_tx), 32'd0);
    chk({p, "_busy"}, 32'(o_busy), 32'd0);
    chk({p, "_halted"}, 32'(o_halted), 32'd0);
    chk({p, "_estado"}, 32'(o_estado), 32'd0);
  endtask

  task automatic reset_dut();
    i_reset = 1'b1;
    exp_bytes.delete();
    exp_campos.delete();
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  initial begin
    int base, t0, d0, n;
    cargar_db();
    cargar_prog(64);
    #1 i_reset = 1'b1;
    #2 chk_ceros("reset");
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;

    // Continuous mode: five ordinary instructions, then HALT.
    cargar_db();
    db[0] = 32'hDEADBEEF;
    cargar_prog(5);
    esperar_reporte();
    t0 = tx_cnt;
    pulso(1'b1, 1'b0, 1'b0);
    esperar(3'd7, 1000, "continuo");
    chk("cont_enables", 32'(en_cnt), 32'd5);
    chk("cont_halted", 32'(o_halted), 32'd1);
    chk("cont_bytes", 32'(tx_cnt - t0), 32'd16);
    chk("cont_pendientes", 32'(exp_bytes.size()), 32'd0);
    chk("cont_busy_done", 32'(o_busy), 32'd0);
    pulso(1'b1, 1'b0, 1'b0);
    chk("done_a_idle", 32'(o_estado), 32'd0);
    chk("done_borra_halted", 32'(o_halted), 32'd0);

    // Step mode: three steps over ordinary instructions, then a step onto HALT.
    reset_dut();
    cargar_db();
    cargar_prog(3);
    pulso(1'b1, 1'b0, 1'b1);
    esperar(3'd2, 10, "entrada_step");
    for (int k = 0; k < 3; k++) begin
      base = en_cnt;
      t0   = tx_cnt;
      esperar_reporte();
      if (k == 2) pulso(1'b1, 1'b1, 1'b0);
      else        pulso(1'b0, 1'b1, 1'b1);
      if (k == 0) begin
        esperar(3'd6, 100, "dump_wait");
        pulso(1'b0, 1'b1, 1'b1);
      end
      esperar(3'd2, 1000, "fin_step");
      chk("step_enable", 32'(en_cnt - base), 32'd1);
      chk("step_bytes", 32'(tx_cnt - t0), 32'd16);
      chk("step_halted", 32'(o_halted), 32'd0);
      chk("step_busy", 32'(o_busy), 32'd1);
      if (k == 0) begin
        repeat (5) @(negedge i_clock);
        chk("step_no_encolado", 32'(o_estado), 32'd2);
        chk("step_no_encolado_en", 32'(en_cnt - base), 32'd1);
      end
      if (k == 1) begin
        pulso(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge i_clock);
        chk("start_ignorado", 32'(o_estado), 32'd2);
      end
    end
    base = en_cnt;
    t0   = tx_cnt;
    esperar_reporte();
    pulso(1'b0, 1'b1, 1'b1);
    esperar(3'd7, 1000, "step_halt");
    chk("halt_enable", 32'(en_cnt - base), 32'd0);
    chk("halt_halted", 32'(o_halted), 32'd1);
    chk("halt_bytes", 32'(tx_cnt - t0), 32'd16);
    pulso(1'b1, 1'b0, 1'b0);
    chk("halt_idle", 32'(o_estado), 32'd0);
    chk("halt_borrado", 32'(o_halted), 32'd0);

    // Reset in the middle of a report, right after the second byte completes.
    reset_dut();
    cargar_db();
    cargar_prog(2);
    esperar_reporte();
    d0 = done_cnt;
    pulso(1'b1, 1'b0, 1'b0);
    n = 0;
    while (done_cnt < d0 + 2 && n < 1000) begin
      @(posedge i_clock);
      n++;
    end
    chk("dos_bytes_antes_reset", 32'(done_cnt - d0), 32'd2);
    #3 i_reset = 1'b1;
    #1 chk_ceros("reset_async");
    exp_bytes.delete();
    exp_campos.delete();
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    t0 = tx_cnt;
    @(posedge i_clock);
    #1 manual_done = 1'b1;
    @(posedge i_clock);
    #1 manual_done = 1'b0;
    repeat (3) @(negedge i_clock);
    chk("done_tardio_estado", 32'(o_estado), 32'd0);
    chk("done_tardio_tx", 32'(tx_cnt - t0), 32'd0);
    chk("done_tardio_busy", 32'(o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
